// File: rtl/id_switch_pkg.sv
// Shared constants for the board ID switch block: register map, bus width and
// init sequencer state encoding.
package id_switch_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] ADDR_STABLE   = 2'd0;
  localparam logic [1:0] ADDR_RAW      = 2'd1;
  localparam logic [1:0] ADDR_CHANGED  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd3;

  typedef logic [1:0] init_state_t;
  localparam init_state_t S_INIT = 2'd0;
  localparam init_state_t S_LOAD = 2'd1;
  localparam init_state_t S_RUN  = 2'd2;

endpackage

// File: rtl/id_switch_debounce_avmm_debounce_bit.sv
// One switch input: synchroniser chain, hold counter, debounced level and a
// single-cycle accept pulse on the edge where a new level is taken.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic sw,
  input  logic load,
  input  logic run,
  output logic sw_sync,
  output logic stable,
  output logic accept
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   differs;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) sync_q <= '0;
    else             sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign differs = sw_sync ^ stable;
  // The terminal compare both accepts the new level and keeps the counter from wrapping.
  assign accept  = run && differs && (cnt == CNT_LAST);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      stable <= sw_sync;
      cnt    <= '0;
    end else if (run) begin
      if (!differs) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sw_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/id_switch_debounce_avmm.sv
// Board ID switch reader: per-bit debounce, sticky change flags with maskable
// irq, debug toggle on every accepted change, Avalon-MM register access.
module id_switch_debounce_avmm
  import id_switch_pkg::*;
#(
  parameter int SW_WIDTH        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic [1:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_WIDTH-1:0] avs_writedata,
  output logic [DATA_WIDTH-1:0] avs_readdata,
  output logic                  irq,
  output logic                  debug_out1
);

  localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

  init_state_t           state;
  logic [2:0]            init_cnt;
  logic                  load;
  logic                  run;
  logic [SW_WIDTH-1:0]   sw_sync;
  logic [SW_WIDTH-1:0]   stable;
  logic [SW_WIDTH-1:0]   accept;
  logic [SW_WIDTH-1:0]   changed;
  logic [SW_WIDTH-1:0]   irq_mask;
  logic [SW_WIDTH-1:0]   w1c;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_wdata;

  // Switch values present at power-up are loaded silently once the synchronisers have filled.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) state <= S_LOAD;
          else                       init_cnt <= init_cnt + 3'd1;
        end
        S_LOAD:  state <= S_RUN;
        S_RUN:   state <= S_RUN;
        default: state <= S_INIT;
      endcase
    end
  end

  assign load = (state == S_LOAD);
  assign run  = (state == S_RUN);

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .sw         (sw[g]),
      .load       (load),
      .run        (run),
      .sw_sync    (sw_sync[g]),
      .stable     (stable[g]),
      .accept     (accept[g])
    );
  end

  assign w1c = (avs_write && avs_address == ADDR_CHANGED) ? avs_writedata[SW_WIDTH-1:0] : '0;
  assign unused_wdata = ^avs_writedata;

  // A hardware set in the same cycle as a W1C clear wins, so no change is lost.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      changed    <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
      debug_out1 <= 1'b0;
    end else begin
      changed    <= (changed & ~w1c) | accept;
      irq        <= run && |(changed & irq_mask);
      debug_out1 <= debug_out1 ^ (|accept);
      if (avs_write && avs_address == ADDR_IRQ_MASK)
        irq_mask <= avs_writedata[SW_WIDTH-1:0];
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    case (avs_address)
      ADDR_STABLE:   rd_mux[SW_WIDTH-1:0] = stable;
      ADDR_RAW:      rd_mux[SW_WIDTH-1:0] = sw_sync;
      ADDR_CHANGED:  rd_mux[SW_WIDTH-1:0] = changed;
      ADDR_IRQ_MASK: rd_mux[SW_WIDTH-1:0] = irq_mask;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)   avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_id_switch_debounce_avmm.sv
// Randomised and directed bench for id_switch_debounce_avmm against a
// history-window reference model of the debounce and register behaviour.
module tb_id_switch_debounce_avmm;
  import id_switch_pkg::*;

  localparam int SW = 4;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int LOAD_EDGE = SS + 2;

  logic            clk_clk = 1'b0;
  logic            reset_reset;
  logic [SW-1:0]   sw;
  logic [1:0]      avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            irq;
  logic            debug_out1;

  id_switch_debounce_avmm #(
    .SW_WIDTH(SW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .sw(sw),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .debug_out1(debug_out1)
  );

  always #5 clk_clk = ~clk_clk;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: sw history per edge since reset release; a bit is accepted
  // when its synchronised value differed from the debounced level on each of the
  // last DB run edges since it was last updated.
  int            e;
  logic [SW-1:0] sw_at [0:8191];
  int            last [SW];
  logic [SW-1:0] m_stable, m_changed, m_mask, cur_sw;
  logic          m_irq, m_dbg;
  logic [31:0]   m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [SW-1:0] sync_at(input int j);
    if (j > SS) return sw_at[j-SS];
    return '0;
  endfunction

  function automatic logic window_ok(input int i);
    logic [SW-1:0] s;
    if (e - DB + 1 <= last[i]) return 1'b0;
    for (int j = e - DB + 1; j <= e; j++) begin
      s = sync_at(j);
      if (s[i] == m_stable[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    e = 0; m_stable = '0; m_changed = '0; m_mask = '0;
    m_irq = 1'b0; m_dbg = 1'b0; m_rdata = '0;
    for (int i = 0; i < SW; i++) last[i] = 0;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic [1:0] addr,
                            input logic [31:0] wd);
    logic [SW-1:0] sync, acc, nchg;
    e++;
    sw_at[e] = cur_sw;
    sync = sync_at(e);
    acc = '0;
    if (e > LOAD_EDGE)
      for (int i = 0; i < SW; i++) acc[i] = window_ok(i);
    if (rd) begin
      case (addr)
        ADDR_STABLE:  m_rdata = 32'(m_stable);
        ADDR_RAW:     m_rdata = 32'(sync);
        ADDR_CHANGED: m_rdata = 32'(m_changed);
        default:      m_rdata = 32'(m_mask);
      endcase
    end
    nchg = m_changed;
    if (wr && addr == ADDR_CHANGED) nchg = nchg & ~wd[SW-1:0];
    nchg = nchg | acc;
    m_irq = (e > LOAD_EDGE) && (|(m_changed & m_mask));
    if (wr && addr == ADDR_IRQ_MASK) m_mask = wd[SW-1:0];
    m_changed = nchg;
    if (|acc) m_dbg = ~m_dbg;
    if (e == LOAD_EDGE) begin
      m_stable = sync;
      for (int i = 0; i < SW; i++) last[i] = e;
    end
    for (int i = 0; i < SW; i++)
      if (acc[i]) begin
        m_stable[i] = sync[i];
        last[i] = e;
      end
  endtask

  // One clock: drive at the negedge, model the posedge, compare at the next negedge.
  task automatic cycle(input logic rd, input logic wr, input logic [1:0] addr,
                       input logic [31:0] wd);
    sw = cur_sw; avs_read = rd; avs_write = wr; avs_address = addr; avs_writedata = wd;
    @(posedge clk_clk);
    model_edge(rd, wr, addr, wd);
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("irq", 32'(irq), 32'(m_irq));
    check("debug_out1", 32'(debug_out1), 32'(m_dbg));
    check("readdata", avs_readdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd_reg(input logic [1:0] addr, output logic [31:0] val);
    cycle(1'b1, 1'b0, addr, 32'd0);
    val = avs_readdata;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
    cycle(1'b0, 1'b1, addr, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic        d0;
    int          n, toggles, left, op;

    reset_reset = 1'b1; cur_sw = 4'hA; sw = 4'hA;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = 2'd0; avs_writedata = '0;
    model_reset();
    @(negedge clk_clk); @(negedge clk_clk);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_debug", 32'(debug_out1), 32'd0);
    reset_reset = 1'b0;

    // Power-up value is loaded without flagging a change.
    idle(10);
    rd_reg(ADDR_STABLE, v);  check("stable_init", v, 32'hA);
    rd_reg(ADDR_CHANGED, v); check("changed_init", v, 32'h0);

    // Single-bit change: accepted exactly SS+DB edges after the input moves.
    wr_reg(ADDR_IRQ_MASK, 32'h1);
    cur_sw = 4'hB; d0 = debug_out1; n = 1;
    while (n <= 40) begin
      idle(1);
      if (debug_out1 != d0) break;
      n++;
    end
    check("accept_latency", 32'(n), 32'(SS + DB));
    idle(1);
    check("irq_after_accept", 32'(irq), 32'd1);
    rd_reg(ADDR_STABLE, v);  check("stable_b", v, 32'hB);
    rd_reg(ADDR_CHANGED, v); check("changed_b", v, 32'h1);

    // Glitch shorter than the debounce window is rejected; RAW shows it.
    d0 = debug_out1;
    cur_sw = 4'hF;
    for (int k = 0; k < 5; k++) rd_reg(ADDR_RAW, v);
    cur_sw = 4'hB;
    for (int k = 0; k < 4; k++) rd_reg(ADDR_RAW, v);
    idle(10);
    rd_reg(ADDR_STABLE, v);  check("stable_glitch", v, 32'hB);
    rd_reg(ADDR_CHANGED, v); check("changed_glitch", v, 32'h1);
    check("debug_glitch", 32'(debug_out1), 32'(d0));

    // W1C of bit 0 on the very edge bit 0 re-accepts: the set wins.
    cur_sw = 4'hA;
    idle(SS + DB - 1);
    wr_reg(ADDR_CHANGED, 32'h1);
    rd_reg(ADDR_CHANGED, v); check("changed_set_wins", v, 32'h1);
    wr_reg(ADDR_CHANGED, 32'h1);
    check("irq_hold_after_w1c", 32'(irq), 32'd1);
    idle(1);
    check("irq_drop_after_w1c", 32'(irq), 32'd0);
    rd_reg(ADDR_CHANGED, v); check("changed_cleared", v, 32'h0);

    // Two bits accepted together give one debug toggle.
    cur_sw = 4'h3; d0 = debug_out1; toggles = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (debug_out1 != d0) begin toggles++; d0 = debug_out1; end
    end
    check("multi_toggle_count", 32'(toggles), 32'd1);
    rd_reg(ADDR_CHANGED, v); check("changed_multi", v, 32'h9);
    wr_reg(ADDR_IRQ_MASK, 32'h8); idle(1);
    check("irq_mask8", 32'(irq), 32'd1);
    wr_reg(ADDR_IRQ_MASK, 32'h0); idle(1);
    check("irq_mask0", 32'(irq), 32'd0);

    // Reset in the middle of a debounce, then silent reload.
    cur_sw = 4'h7;
    idle(SS + 5);
    reset_reset = 1'b1;
    #1;
    check("midrst_readdata", avs_readdata, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_debug", 32'(debug_out1), 32'd0);
    model_reset();
    @(negedge clk_clk); @(negedge clk_clk);
    reset_reset = 1'b0;
    idle(10);
    rd_reg(ADDR_CHANGED, v); check("changed_after_rst", v, 32'h0);
    rd_reg(ADDR_STABLE, v);  check("stable_after_rst", v, 32'h7);

    // Random switch activity with random hold lengths and random bus traffic.
    n = 0;
    while (n < 1500) begin
      cur_sw = 4'($urandom);
      left = $urandom_range(1, 20);
      for (int k = 0; k < left; k++) begin
        op = $urandom_range(0, 9);
        case (op)
          0, 1, 2, 3, 4: cycle(1'b1, 1'b0, 2'($urandom), 32'd0);
          5:             wr_reg(ADDR_CHANGED, $urandom);
          6:             wr_reg(ADDR_IRQ_MASK, $urandom);
          7:             wr_reg(2'($urandom_range(0, 1)), $urandom);
          default:       idle(1);
        endcase
        n++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_switch_debounce_avmm.md
Name: id_switch_debounce_avmm

Overview:
- Parametrised successor to the fixed 4-bit ID switch input of vidor_sys.
- Takes a SW_WIDTH-bit board ID/DIP switch bus, synchronises it and debounces each bit independently.
- Latches a per-bit sticky change flag and raises a maskable interrupt on change.
- Exposes all state through an Avalon-MM slave so the soft CPU and SPI bridge master can read the board ID; drives a debug pin that toggles on every debounced change.

Parameters:
- SW_WIDTH, 4: number of switch inputs; range 1..32.
- SYNC_STAGES, 2: synchroniser flops per input; range 2..4.
- DEBOUNCE_CYCLES, 50000: consecutive clk_clk cycles a new level must hold before it is accepted; range 2..2^20.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES): derived debounce counter width; not user-overridden.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- sw  in  SW_WIDTH  raw asynchronous switch inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- irq  out  1  level interrupt.
- debug_out1  out  1  toggles on each debounced change event.

Behaviour:
- Reset: all synchroniser flops, stable, changed, irq_mask, counters, avs_readdata, irq and debug_out1 = 0; FSM = S_INIT.
- Synchroniser: SYNC_STAGES-flop chain per bit; output is sw_sync.
- Init FSM, S_INIT:
  - Counts SYNC_STAGES+1 cycles, then moves to S_LOAD.
  - In this state: no debounce, no flags, irq forced 0.
- Init FSM, S_LOAD (one cycle): stable <= sw_sync; changed stays 0; moves to S_RUN. Power-up switch values never raise a change.
- Init FSM, S_RUN: normal operation. Stays there until reset.
- Per-bit debounce in S_RUN:
  - If sw_sync[i] == stable[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and the bit still differs, stable[i] <= sw_sync[i], cnt[i] <= 0 and changed[i] <= 1, all on the same edge.
  - Glitch shorter than DEBOUNCE_CYCLES: counter clears, stable unchanged, no flag.
  - Counter never wraps; the ==DEBOUNCE_CYCLES-1 compare terminates it.
- Event: event = OR of per-bit accept pulses in one cycle. debug_out1 <= ~debug_out1 on each event cycle. Multiple bits accepted in the same cycle = one toggle.
- Register map (readdata zero-extended above SW_WIDTH; unused bits read 0):
  - 0 STABLE (RO): debounced value.
  - 1 RAW (RO): sw_sync.
  - 2 CHANGED (W1C): writing 1 to bit i clears changed[i].
  - 3 IRQ_MASK (RW): low SW_WIDTH bits.
  - Writes to RO addresses are ignored.
- Read timing: fixed read latency 1. avs_readdata is registered on the cycle after avs_read and holds its value until the next read. No waitrequest.
- Simultaneous events:
  - Hardware set and W1C clear of the same CHANGED bit in one cycle: set wins, bit stays 1.
  - Read of CHANGED in the same cycle as a set returns the pre-set value.
- irq: registered, irq <= |(changed & irq_mask) in S_RUN, else 0. Deasserts one cycle after the clearing write or mask write.
- Reset mid-operation: asynchronous return to reset values; the FSM reruns the init sequence and reloads stable without flagging.

Decomposition:
- Shared package id_switch_pkg holds:
  - register address constants ADDR_STABLE=0, ADDR_RAW=1, ADDR_CHANGED=2, ADDR_IRQ_MASK=3;
  - the init FSM state enum (S_INIT, S_LOAD, S_RUN);
  - the data width constant 32.
- One sub-module, debounce_bit, parametrised by DEBOUNCE_CYCLES: synchroniser chain, counter, stable bit and accept pulse. Instantiated SW_WIDTH times by generate. Top level owns the FSM, registers, irq and debug toggle.

Test Plan (SW_WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8):
- Hold sw=4'b1010 through reset release, wait 10 cycles. Expected: STABLE=0xA, CHANGED=0, irq=0, debug_out1=0.
- From stable 0xA, set sw=0xB and hold. Expected:
  - STABLE becomes 0xB exactly SYNC_STAGES+8 cycles after the edge;
  - CHANGED=0x1;
  - debug_out1 toggles once;
  - with IRQ_MASK=0x1, irq rises the following cycle.
- Pulse sw[2] for 5 cycles, then return. Expected: STABLE, CHANGED and debug_out1 unchanged; RAW shows the pulse delayed by 2 cycles.
- With CHANGED=0x1, write 0x1 to address 2 in the same cycle bit 0 re-accepts a change. Expected: CHANGED stays 0x1. A later plain W1C gives CHANGED=0 and irq drops one cycle later.
- Flip sw bits 0 and 3 together and hold. Expected: a single debug_out1 toggle, CHANGED=0x9. With IRQ_MASK=0x8, irq=1; after writing IRQ_MASK=0, irq=0.
- Assert reset_reset mid-debounce (counter=5). Expected: all outputs 0 immediately; after release, re-init loads current sw with no CHANGED bits set.
